// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the 4-source round-robin stream arbiter
package arb_pkg;
  localparam int N_SRC = 4;

  typedef logic [1:0] src_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mux4_gate.sv
// rtl/mux4_gate.sv - gate-level 4:1 mux, one AND-OR tree per data bit
module mux4_gate #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  logic s0n, s1n;

  not u_n0 (s0n, sel[0]);
  not u_n1 (s1n, sel[1]);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic t0, t1, t2, t3;
    and u_a0 (t0, d0[b], s1n,    s0n);
    and u_a1 (t1, d1[b], s1n,    sel[0]);
    and u_a2 (t2, d2[b], sel[1], s0n);
    and u_a3 (t3, d3[b], sel[1], sel[0]);
    or  u_o  (y[b], t0, t1, t2, t3);
  end

endmodule

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - rotate-priority picker: first set req at or after ptr, wrapping 3->0
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output logic             any,
  output src_idx_t         grant
);

  logic [2*N_SRC-1:0] req_dbl;
  logic [N_SRC-1:0]   req_rot;
  src_idx_t           offset;

  // Rotating right by ptr puts the highest-priority source at bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_SRC];

  always_comb begin
    offset = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = src_idx_t'(i);
    end
  end

  assign any   = |req;
  assign grant = ptr + offset;

endmodule

// File: rtl/rr_arb_stream_4.sv
// rtl/rr_arb_stream_4.sv - 4-source round-robin stream arbiter with 1-entry registered output
module rr_arb_stream_4
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] in_valid,
  input  logic [W-1:0]     in_data_0,
  input  logic [W-1:0]     in_data_1,
  input  logic [W-1:0]     in_data_2,
  input  logic [W-1:0]     in_data_3,
  output logic [N_SRC-1:0] in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output src_idx_t         out_src,
  input  logic             out_ready
);

  arb_state_t state, state_nxt;
  src_idx_t   ptr;
  src_idx_t   grant;
  logic       any;
  logic       load;
  logic       take;
  logic [W-1:0] mux_y;

  rr_pick_4 u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .any   (any),
    .grant (grant)
  );

  mux4_gate #(.W(W)) u_mux (
    .d0  (in_data_0),
    .d1  (in_data_1),
    .d2  (in_data_2),
    .d3  (in_data_3),
    .sel (grant),
    .y   (mux_y)
  );

  assign out_valid = (state == ST_FULL);
  // Popping and refilling in the same cycle keeps full throughput.
  assign load      = ~out_valid | out_ready;
  assign take      = rst_n & load & any;

  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    if (load) state_nxt = any ? ST_FULL : ST_EMPTY;
    if (take) in_ready = N_SRC'(1) << grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        out_data <= mux_y;
        out_src  <= grant;
        ptr      <= grant + src_idx_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_stream_4.sv
// tb/tb_rr_arb_stream_4.sv - randomized self-checking bench for rr_arb_stream_4
module tb_rr_arb_stream_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  int mvalid, mdata, msrc, mptr;

  always #5 clk = ~clk;

  rr_arb_stream_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_0 (d0),
    .in_data_1 (d1),
    .in_data_2 (d2),
    .in_data_3 (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int word(input int i);
    case (i)
      0:       return int'(d0);
      1:       return int'(d1);
      2:       return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  task automatic model_reset();
    mvalid = 0; mdata = 0; msrc = 0; mptr = 0;
  endtask

  // Inputs are already applied; check the cycle, then advance one edge and the model.
  task automatic step();
    int g;
    int ld;
    int exp_rdy;
    #1;
    g  = -1;
    ld = (mvalid == 0) || out_ready;
    if (rst_n && ld) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && in_valid[(mptr + k) % 4]) g = (mptr + k) % 4;
      end
    end
    exp_rdy = (g >= 0) ? (1 << g) : 0;
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(mvalid));
    check("out_data",  32'(out_data),  32'(mdata));
    check("out_src",   32'(out_src),   32'(msrc));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ld) begin
      if (g >= 0) begin
        mvalid = 1;
        mdata  = word(g);
        msrc   = g;
        mptr   = (g + 1) % 4;
      end else begin
        mvalid = 0;
      end
    end
    #1;
  endtask

  task automatic set_data(input int a, input int b, input int c, input int d);
    d0 = W'(a); d1 = W'(b); d2 = W'(c); d3 = W'(d);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'($urandom);
    out_ready = 1'($urandom);
    set_data($urandom, $urandom, $urandom, $urandom);
    model_reset();
    @(posedge clk);
    #1;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in_valid = 4'($urandom);
      set_data($urandom, $urandom, $urandom, $urandom);
      step();
    end
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);

    // all four valid: round-robin from source 0
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    set_data('hA, 'hB, 'hC, 'hD);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_src",  32'(out_src),  32'(i % 4));
      check("rr_data", 32'(out_data), 32'('hA + (i % 4)));
    end

    // single requester, then ptr moves past it
    in_valid = 4'b0100; set_data(0, 0, 5, 0);
    step();
    check("single_data", 32'(out_data), 32'h5);
    check("single_src",  32'(out_src),  32'd2);
    in_valid = 4'b1111;
    step();
    check("after_single_src", 32'(out_src), 32'd3);

    // backpressure holds a full output
    set_data(7, 7, 7, 7);
    step();
    out_ready = 1'b0;
    set_data(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data", 32'(out_data), 32'h7);
    end
    out_ready = 1'b1;
    step();
    check("bp_refill_valid", 32'(out_valid), 32'd1);
    check("bp_refill_src",   32'(out_src),   32'd1);
    check("bp_refill_data",  32'(out_data),  32'h2);

    // drain
    in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_src",   32'(out_src),   32'd1);
    step();

    // reset mid-stream
    in_valid = 4'b1111;
    step();
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("midrst_src", 32'(out_src), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_data($urandom, $urandom, $urandom, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
